// File: rtl/scalar_pkg.sv
// Shared types for the scalar forwarding/hazard controller: operand-forward selects,
// the stall FSM state and the hardwired-zero register index.
package scalar_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/scalar_fwd_ctrl_if.sv
// ID-stage request, EX/MEM/WB result data and forward/stall responses of the scalar
// forwarding controller. The pipeline drives through master; the controller is the slave.
interface scalar_fwd_ctrl_if #(
    parameter int unsigned N     = 24,
    parameter int unsigned REG_W = 4
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rs3;
    logic [REG_W-1:0] id_rd;
    logic             id_we;
    logic             id_is_load;
    logic             flush;
    logic [N-1:0]     mem_result;
    logic [N-1:0]     wb_result;
    logic             stall;
    logic             bubble;
    logic             Fa;
    logic             Fb;
    logic             Fc;
    logic [N-1:0]     Forward1;
    logic [N-1:0]     Forward2;
    logic [N-1:0]     Forward3;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs3, id_rd, id_we, id_is_load, flush,
        output mem_result, wb_result,
        input  stall, bubble, Fa, Fb, Fc, Forward1, Forward2, Forward3
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs3, id_rd, id_we, id_is_load, flush,
        input  mem_result, wb_result,
        output stall, bubble, Fa, Fb, Fc, Forward1, Forward2, Forward3
    );

endinterface

// File: rtl/scalar_fwd_ctrl_fwd_match.sv
// Matches one ID source index against the EX and MEM destination shadows; returns the
// youngest-producer forward select and whether the EX producer is a load.
module fwd_match
    import scalar_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic             valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_ld,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    output fwd_sel_t         sel,
    output logic             load_hit
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;

    // r0 reads as zero, so it never needs a forward or a load-use stall.
    assign rs_live = valid && (rs != REG_W'(REG_ZERO));
    assign ex_hit  = rs_live && ex_we && (rs == ex_rd);
    assign mem_hit = rs_live && mem_we && (rs == mem_rd);

    always_comb begin
        sel = FWD_NONE;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

    assign load_hit = ex_hit && ex_ld;

endmodule

// File: rtl/scalar_fwd_ctrl.sv
// Scalar pipeline forwarding and load-use hazard controller.
// Define SCALAR_FWD_STATS_EN to add saturating fwd_cnt/stall_cnt outputs.
module scalar_fwd_ctrl
    import scalar_pkg::*;
#(
    parameter int unsigned N     = 24,
    parameter int unsigned REG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SCALAR_FWD_STATS_EN
    output logic [15:0] fwd_cnt,
    output logic [15:0] stall_cnt,
`endif
    scalar_fwd_ctrl_if.slave bus
);

    logic [REG_W-1:0] ex_rd_q;
    logic             ex_we_q;
    logic             ex_ld_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_we_q;

    logic [REG_W-1:0] rs [3];
    fwd_sel_t         sel_d [3];
    fwd_sel_t         sel_q [3];
    logic [2:0]       load_hit;
    logic [N-1:0]     fwd_data [3];

    fsm_state_t state_q;
    fsm_state_t state_d;
    logic       hazard;
    logic       stall;
    logic       bubble;

    assign rs[0] = bus.id_rs1;
    assign rs[1] = bus.id_rs2;
    assign rs[2] = bus.id_rs3;

    for (genvar k = 0; k < 3; k++) begin : g_match
        fwd_match #(
            .REG_W (REG_W)
        ) u_match (
            .valid    (bus.id_valid),
            .rs       (rs[k]),
            .ex_rd    (ex_rd_q),
            .ex_we    (ex_we_q),
            .ex_ld    (ex_ld_q),
            .mem_rd   (mem_rd_q),
            .mem_we   (mem_we_q),
            .sel      (sel_d[k]),
            .load_hit (load_hit[k])
        );
    end

    assign hazard = |load_hit;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                // EX holds the bubble now, so the held ID instruction cannot hazard again.
                bubble  = bus.flush;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            ex_rd_q  <= '0;
            ex_we_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_we_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                sel_q[k] <= FWD_NONE;
            end
        end else begin
            state_q  <= state_d;
            ex_rd_q  <= bus.id_rd;
            ex_we_q  <= bus.id_valid && bus.id_we && !bubble;
            ex_ld_q  <= bus.id_valid && bus.id_is_load && !bubble;
            mem_rd_q <= ex_rd_q;
            mem_we_q <= ex_we_q;
            // Selects are re-evaluated every ID cycle, so a held instruction never keeps stale ones.
            for (int k = 0; k < 3; k++) begin
                sel_q[k] <= bubble ? FWD_NONE : sel_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            fwd_data[k] = '0;
            if (sel_q[k] == FWD_MEM) begin
                fwd_data[k] = bus.mem_result;
            end else if (sel_q[k] == FWD_WB) begin
                fwd_data[k] = bus.wb_result;
            end
        end
    end

    assign bus.stall    = stall;
    assign bus.bubble   = bubble;
    assign bus.Fa       = (sel_q[0] != FWD_NONE);
    assign bus.Fb       = (sel_q[1] != FWD_NONE);
    assign bus.Fc       = (sel_q[2] != FWD_NONE);
    assign bus.Forward1 = fwd_data[0];
    assign bus.Forward2 = fwd_data[1];
    assign bus.Forward3 = fwd_data[2];

`ifdef SCALAR_FWD_STATS_EN
    logic [15:0] fwd_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        any_fwd;

    assign any_fwd = bus.Fa || bus.Fb || bus.Fc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (any_fwd && (fwd_cnt_q != 16'hFFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_scalar_fwd_ctrl.sv
// Bench for scalar_fwd_ctrl: directed scenarios plus a randomized instruction stream
// checked against an in-flight-instruction model of the pipeline.
module tb_scalar_fwd_ctrl;

    localparam int unsigned N     = 24;
    localparam int unsigned REG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    scalar_fwd_ctrl_if #(.N(N), .REG_W(REG_W)) bus ();

`ifdef SCALAR_FWD_STATS_EN
    logic [15:0] fwd_cnt;
    logic [15:0] stall_cnt;
`endif

    scalar_fwd_ctrl #(
        .N     (N),
        .REG_W (REG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SCALAR_FWD_STATS_EN
        .fwd_cnt   (fwd_cnt),
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: the instructions occupying EX (age 0) and MEM (age 1), and what each EX operand
    // was told to take: 0 nothing, 1 the MEM-stage result, 2 the WB-stage result.
    typedef struct {
        logic       writes;
        logic [3:0] rd;
        logic       ld;
    } slot_t;

    slot_t      pipe [2];
    int         m_sel [3];
    int         nxt_sel [3];
    int         m_fwd_cnt;
    int         m_stall_cnt;
    logic       exp_stall;
    logic       exp_bubble;
    logic [2:0] exp_f;
    logic [23:0] exp_fw [3];

    function automatic logic [3:0] rs_of(input int k);
        if (k == 0) return bus.id_rs1;
        if (k == 1) return bus.id_rs2;
        return bus.id_rs3;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 2; a++) begin
            pipe[a].writes = 1'b0;
            pipe[a].rd     = '0;
            pipe[a].ld     = 1'b0;
        end
        for (int k = 0; k < 3; k++) m_sel[k] = 0;
        m_fwd_cnt   = 0;
        m_stall_cnt = 0;
    endtask

    task automatic model_eval();
        logic hz;
        hz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.id_valid && pipe[0].writes && pipe[0].ld && pipe[0].rd != 0 &&
                rs_of(k) == pipe[0].rd) hz = 1'b1;
        end
        exp_bubble = bus.flush || hz;
        exp_stall  = hz && !bus.flush;
        for (int k = 0; k < 3; k++) begin
            exp_f[2-k] = (m_sel[k] != 0);
            exp_fw[k]  = (m_sel[k] == 1) ? bus.mem_result :
                         (m_sel[k] == 2) ? bus.wb_result : 24'h0;
            nxt_sel[k] = 0;
            // Oldest first so the youngest matching producer wins.
            if (!exp_bubble && bus.id_valid && rs_of(k) != 0) begin
                for (int a = 1; a >= 0; a--) begin
                    if (pipe[a].writes && pipe[a].rd == rs_of(k)) nxt_sel[k] = a + 1;
                end
            end
        end
    endtask

    task automatic apply();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if ((m_sel[0] != 0 || m_sel[1] != 0 || m_sel[2] != 0) && m_fwd_cnt < 65535)
                m_fwd_cnt++;
            if (exp_stall && m_stall_cnt < 65535) m_stall_cnt++;
            pipe[1]        = pipe[0];
            pipe[0].writes = bus.id_valid && bus.id_we && !exp_bubble;
            pipe[0].ld     = bus.id_valid && bus.id_is_load && !exp_bubble;
            pipe[0].rd     = bus.id_rd;
            for (int k = 0; k < 3; k++) m_sel[k] = nxt_sel[k];
        end
        #1;
    endtask

    task automatic set_id(input logic v, input int r1, input int r2, input int r3,
                          input int rd, input logic we, input logic ld);
        bus.id_valid   = v;
        bus.id_rs1     = 4'(r1);
        bus.id_rs2     = 4'(r2);
        bus.id_rs3     = 4'(r3);
        bus.id_rd      = 4'(rd);
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.flush      = 1'b0;
    endtask

    task automatic drain();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h5A5A5A;
        bus.wb_result  = 24'hA5A5A5;
        tick();
        tick();
        rst = 1'b0;
        apply();
        checks++;
        if ({bus.stall, bus.bubble} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall_bubble: got %b want 00", {bus.stall, bus.bubble});
        end
        checks++;
        if ({bus.Fa, bus.Fb, bus.Fc} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fsel: got %b want 000", {bus.Fa, bus.Fb, bus.Fc});
        end
        checks++;
        if ({bus.Forward1, bus.Forward2, bus.Forward3} !== 72'h0) begin
            errors++;
            $display("FAIL reset_forward: got %h %h %h want 0", bus.Forward1, bus.Forward2,
                     bus.Forward3);
        end
`ifdef SCALAR_FWD_STATS_EN
        checks++;
        if ({fwd_cnt, stall_cnt} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h want 0", fwd_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_ex_ex();
        set_id(1'b1, 1, 2, 0, 3, 1'b1, 1'b0);       // add r3,r1,r2
        apply();
        tick();
        set_id(1'b1, 3, 2, 0, 4, 1'b1, 1'b0);       // sub r4,r3,r2
        apply();
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL ex_ex_stall: got %b want 0", bus.stall);
        end
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h000123;
        bus.wb_result  = 24'h0F0F0F;
        apply();
        checks++;
        if ({bus.Fa, bus.Fb, bus.Fc} !== 3'b100) begin
            errors++;
            $display("FAIL ex_ex_fsel: got %b want 100", {bus.Fa, bus.Fb, bus.Fc});
        end
        checks++;
        if (bus.Forward1 !== 24'h000123) begin
            errors++;
            $display("FAIL ex_ex_forward1: got %h want 000123", bus.Forward1);
        end
        drain();
    endtask

    task automatic test_mem_ex();
        set_id(1'b1, 1, 2, 0, 5, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b1, 1, 2, 0, 9, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b1, 1, 5, 0, 10, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h000001;
        bus.wb_result  = 24'h00ABCD;
        apply();
        checks++;
        if ({bus.Fa, bus.Fb, bus.Fc} !== 3'b010) begin
            errors++;
            $display("FAIL mem_ex_fsel: got %b want 010", {bus.Fa, bus.Fb, bus.Fc});
        end
        checks++;
        if (bus.Forward2 !== 24'h00ABCD) begin
            errors++;
            $display("FAIL mem_ex_forward2: got %h want 00abcd", bus.Forward2);
        end
        drain();
    endtask

    task automatic test_priority();
        set_id(1'b1, 1, 2, 0, 6, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b1, 1, 2, 0, 6, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b1, 1, 2, 6, 11, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h111111;
        bus.wb_result  = 24'h222222;
        apply();
        checks++;
        if (bus.Fc !== 1'b1 || bus.Forward3 !== 24'h111111) begin
            errors++;
            $display("FAIL priority_fc: got Fc=%b Forward3=%h want Fc=1 Forward3=111111",
                     bus.Fc, bus.Forward3);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 1, 0, 0, 7, 1'b1, 1'b1);       // ld r7
        apply();
        tick();
        set_id(1'b1, 7, 1, 0, 8, 1'b1, 1'b0);       // add r8,r7,r1
        apply();
        checks++;
        if ({bus.stall, bus.bubble} !== 2'b11) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 11", {bus.stall, bus.bubble});
        end
        tick();
        apply();                                     // same instruction held in ID
        checks++;
        if ({bus.stall, bus.bubble, bus.Fa} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_release: got stall,bubble,Fa=%b want 000",
                     {bus.stall, bus.bubble, bus.Fa});
        end
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h000111;
        bus.wb_result  = 24'h00BEEF;
        apply();
        checks++;
        if (bus.Fa !== 1'b1 || bus.Forward1 !== 24'h00BEEF || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_wb: got Fa=%b Forward1=%h stall=%b want 1 00beef 0",
                     bus.Fa, bus.Forward1, bus.stall);
        end
        drain();
    endtask

    task automatic test_r0_flush();
        set_id(1'b1, 1, 2, 0, 0, 1'b1, 1'b0);       // write to r0
        apply();
        tick();
        set_id(1'b1, 0, 0, 0, 12, 1'b1, 1'b0);
        apply();
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h333333;
        apply();
        checks++;
        if (bus.Fa !== 1'b0 || bus.Forward1 !== 24'h0) begin
            errors++;
            $display("FAIL r0_no_fwd: got Fa=%b Forward1=%h want 0 0", bus.Fa, bus.Forward1);
        end
        tick();
        set_id(1'b1, 1, 0, 0, 7, 1'b1, 1'b1);       // ld r7
        apply();
        tick();
        set_id(1'b1, 7, 7, 7, 8, 1'b1, 1'b0);
        bus.flush = 1'b1;
        apply();
        checks++;
        if ({bus.stall, bus.bubble} !== 2'b01) begin
            errors++;
            $display("FAIL flush_hazard: got stall,bubble=%b want 01", {bus.stall, bus.bubble});
        end
        tick();
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        apply();
        checks++;
        if ({bus.Fa, bus.Fb, bus.Fc, bus.stall} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_after: got Fa,Fb,Fc,stall=%b want 0000",
                     {bus.Fa, bus.Fb, bus.Fc, bus.stall});
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 1, 0, 0, 7, 1'b1, 1'b1);
        apply();
        tick();
        set_id(1'b1, 2, 7, 0, 8, 1'b1, 1'b0);
        apply();
        tick();                                      // now in the stall-release cycle
        rst = 1'b1;
        apply();
        tick();
        rst = 1'b0;
        set_id(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.mem_result = 24'h444444;
        bus.wb_result  = 24'h555555;
        apply();
        checks++;
        if ({bus.stall, bus.bubble, bus.Fa, bus.Fb, bus.Fc} !== 5'b0 ||
            {bus.Forward1, bus.Forward2, bus.Forward3} !== 72'h0) begin
            errors++;
            $display("FAIL rst_mid_stall_outputs: got %b %h %h %h want all 0",
                     {bus.stall, bus.bubble, bus.Fa, bus.Fb, bus.Fc},
                     bus.Forward1, bus.Forward2, bus.Forward3);
        end
`ifdef SCALAR_FWD_STATS_EN
        checks++;
        if ({fwd_cnt, stall_cnt} !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_stall_counters: got %h %h want 0", fwd_cnt, stall_cnt);
        end
`endif
        // A fresh load-use pair must stall straight away, so the FSM is back in RUN.
        tick();
        set_id(1'b1, 1, 0, 0, 9, 1'b1, 1'b1);
        apply();
        tick();
        set_id(1'b1, 0, 0, 9, 10, 1'b1, 1'b0);
        apply();
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stall_run: got stall=%b want 1", bus.stall);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        logic hold;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                set_id($urandom_range(0, 9) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
                       $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4) != 0,
                       $urandom_range(0, 2) == 0);
            end
            bus.flush      = ($urandom_range(0, 9) == 0);
            bus.mem_result = 24'($urandom);
            bus.wb_result  = 24'($urandom);
            apply();
            checks++;
            if ({bus.stall, bus.bubble} !== {exp_stall, exp_bubble}) begin
                errors++;
                $display("FAIL rand_stall_bubble cyc %0d: got %b want %b", c,
                         {bus.stall, bus.bubble}, {exp_stall, exp_bubble});
            end
            checks++;
            if ({bus.Fa, bus.Fb, bus.Fc} !== exp_f) begin
                errors++;
                $display("FAIL rand_fsel cyc %0d: got %b want %b", c,
                         {bus.Fa, bus.Fb, bus.Fc}, exp_f);
            end
            checks++;
            if (bus.Forward1 !== exp_fw[0] || bus.Forward2 !== exp_fw[1] ||
                bus.Forward3 !== exp_fw[2]) begin
                errors++;
                $display("FAIL rand_forward cyc %0d: got %h %h %h want %h %h %h", c,
                         bus.Forward1, bus.Forward2, bus.Forward3,
                         exp_fw[0], exp_fw[1], exp_fw[2]);
            end
            // The pipeline keeps the same instruction in ID while it is stalled.
            hold = exp_stall;
            tick();
        end
`ifdef SCALAR_FWD_STATS_EN
        checks++;
        if (int'(fwd_cnt) != m_fwd_cnt || int'(stall_cnt) != m_stall_cnt) begin
            errors++;
            $display("FAIL rand_counters: got %0d %0d want %0d %0d", fwd_cnt, stall_cnt,
                     m_fwd_cnt, m_stall_cnt);
        end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ex_ex();
        test_mem_ex();
        test_priority();
        test_load_use();
        test_r0_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
